// File: rtl/dmem_responder_if.sv
// Memory-side bus of the data-memory responder.
//   mem_req   : request valid, held for the whole access
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data, already replicated into the active lanes
//   mem_wmask : per-byte write enable (0 for loads)
//   mem_ack   : memory completes the access this cycle
//   mem_rdata : full load word, valid with mem_ack
// master = responder side, slave = memory side.
interface dmem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder between the MEM pipeline stage and a word-wide
// memory with byte masks. Checks size/alignment, issues one request,
// waits for ack (bounded by TIMEOUT) and returns the extended load result.
// Ports:
//   clk, reset (async, active-low)
//   MemRead, MemWrite, Funct3, Addr, WrData : access from the MEM stage
//   RdData     : extended load result, held until the next load completes
//   stall      : freezes the pipeline while the access is in flight
//   misaligned : alignment / illegal-size fault, no request issued
//   timeout    : one-cycle pulse when an access is abandoned
//   mem        : memory-side bus (master modport)
//
// state | meaning
// IDLE  | waiting for a legal access; faults flagged combinationally
// REQ   | mem_req high, waiting for mem_ack or the wait limit
// DONE  | one cycle, RdData valid, pipeline released
module dmem_responder #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Funct3,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WrData,
  output logic [31:0]      RdData,
  output logic             stall,
  output logic             misaligned,
  output logic             timeout,
  dmem_responder_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr, lat_wdata;
  logic [2:0]    lat_f3;
  logic          lat_we;
  logic          timeout_q;

  logic start, ack_hit, to_hit, fault;
  logic legal_f3, aligned, in_req;

  // MemWrite wins when both requests are high, so store legality applies.
  always_comb begin
    legal_f3 = 1'b0;
    if (MemWrite) legal_f3 = (Funct3[2] == 1'b0) && (Funct3[1:0] != 2'b11);
    else          legal_f3 = (Funct3[1:0] != 2'b11) && (Funct3[2:1] != 2'b11);
    case (Funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~Addr[0];
      2'b10:   aligned = (Addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    fault   = 1'b0;
    start   = 1'b0;
    ack_hit = 1'b0;
    to_hit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          if (legal_f3 && aligned) begin
            stall   = 1'b1;
            start   = 1'b1;
            state_n = S_REQ;
          end else begin
            fault = 1'b1;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          ack_hit = 1'b1;
          state_n = S_DONE;
        end else if (cnt == CNT_LAST) begin
          to_hit  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Gated so the fault flag is quiet while reset is held.
  assign misaligned = fault & reset;
  assign timeout    = timeout_q;

  logic [31:0] rd_b, rd_h, load_val;
  assign rd_b = mem.mem_rdata >> {lat_addr[1:0], 3'b000};
  assign rd_h = mem.mem_rdata >> {lat_addr[1], 4'b0000};

  always_comb begin
    case (lat_f3)
      3'b000:  load_val = {{24{rd_b[7]}}, rd_b[7:0]};
      3'b100:  load_val = {24'd0, rd_b[7:0]};
      3'b001:  load_val = {{16{rd_h[15]}}, rd_h[15:0]};
      3'b101:  load_val = {16'd0, rd_h[15:0]};
      default: load_val = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= '0;
      lat_we    <= 1'b0;
      RdData    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      timeout_q <= to_hit;
      if (start) begin
        lat_addr  <= Addr;
        lat_wdata <= WrData;
        lat_f3    <= Funct3;
        lat_we    <= MemWrite;
        cnt       <= '0;
      end else if (state == S_REQ && !mem.mem_ack) begin
        cnt <= cnt + CW'(1);
      end
      // Stores never touch RdData, including an abandoned store.
      if (ack_hit && !lat_we) RdData <= load_val;
      if (to_hit && !lat_we)  RdData <= '0;
    end
  end

  // Bus outputs are derived from the latched access and forced to zero
  // outside REQ, which also makes them drop immediately on reset.
  assign in_req       = (state == S_REQ);
  assign mem.mem_req  = in_req;
  assign mem.mem_we   = in_req & lat_we;
  assign mem.mem_addr = in_req ? {lat_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    mem.mem_wdata = 32'd0;
    mem.mem_wmask = 4'd0;
    if (in_req && lat_we) begin
      case (lat_f3[1:0])
        2'b00: begin
          mem.mem_wdata = {4{lat_wdata[7:0]}};
          mem.mem_wmask = 4'b0001 << lat_addr[1:0];
        end
        2'b01: begin
          mem.mem_wdata = {2{lat_wdata[15:0]}};
          mem.mem_wmask = 4'b0011 << lat_addr[1:0];
        end
        default: begin
          mem.mem_wdata = lat_wdata;
          mem.mem_wmask = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData, RdData;
  logic        stall, misaligned, timeout;

  dmem_responder_if mem_if ();

  dmem_responder #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .Addr       (Addr),
    .WrData     (WrData),
    .RdData     (RdData),
    .stall      (stall),
    .misaligned (misaligned),
    .timeout    (timeout),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] rd_model = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules written as plain arithmetic on sizes and offsets.
  function automatic logic is_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    if (wr) begin
      if (f3 > 3'd2) return 1'b0;
    end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 1'b0;
    end
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [31:0] a, input logic [2:0] f3);
    int unsigned off = a % 4;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (d >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (d >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_mask(input logic [31:0] a, input logic [2:0] f3);
    int unsigned off = a % 4;
    case (f3)
      3'd0:    return 32'(1 << off);
      3'd1:    return 32'(3 << off);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'd0:    return (w & 32'hFF) * 32'h0101_0101;
      3'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // Runs one access starting just after a negedge with the FSM idle.
  // dly = REQ cycle (0-based) in which ack is given; dly >= TMO means no ack.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] d, input int dly, input string tag);
    logic ok;
    logic to;
    ok = is_legal(wr, f3, a);
    to = (dly >= TMO);
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = w;
    #1;
    if (!ok) begin
      chk({tag, " misaligned"}, misaligned, 1);
      chk({tag, " fault stall"}, stall, 0);
      chk({tag, " fault req"}, mem_if.mem_req, 0);
      @(negedge clk);
      #1 chk({tag, " fault no req"}, mem_if.mem_req, 0);
      MemRead = 0; MemWrite = 0;
      #1 chk({tag, " misaligned clear"}, misaligned, 0);
      chk({tag, " fault RdData"}, RdData, rd_model);
      return;
    end
    chk({tag, " idle stall"}, stall, 1);
    chk({tag, " idle misaligned"}, misaligned, 0);
    chk({tag, " idle req"}, mem_if.mem_req, 0);
    @(negedge clk);
    for (int k = 0; k < TMO; k++) begin
      #1;
      chk({tag, " req"}, mem_if.mem_req, 1);
      chk({tag, " req stall"}, stall, 1);
      chk({tag, " addr"}, mem_if.mem_addr, a - (a % 4));
      chk({tag, " we"}, mem_if.mem_we, wr);
      chk({tag, " wmask"}, mem_if.mem_wmask, wr ? exp_mask(a, f3) : 32'd0);
      if (wr) chk({tag, " wdata"}, mem_if.mem_wdata, exp_wdata(w, f3));
      mem_if.mem_ack   = (k == dly);
      mem_if.mem_rdata = (k == dly) ? d : $urandom;
      @(negedge clk);
      mem_if.mem_ack = 0;
      if (k == dly) break;
    end
    if (!wr) rd_model = to ? 32'd0 : exp_load(d, a, f3);
    mem_if.mem_ack   = 1;
    mem_if.mem_rdata = ~d;
    #1;
    chk({tag, " done stall"}, stall, 0);
    chk({tag, " done req"}, mem_if.mem_req, 0);
    chk({tag, " done timeout"}, timeout, to);
    chk({tag, " RdData"}, RdData, rd_model);
    @(negedge clk);
    mem_if.mem_ack = 0;
    MemRead = 0; MemWrite = 0;
    #1;
    chk({tag, " idle after stall"}, stall, 0);
    chk({tag, " timeout cleared"}, timeout, 0);
    chk({tag, " RdData held"}, RdData, rd_model);
    chk({tag, " idle after req"}, mem_if.mem_req, 0);
  endtask

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    reset = 0;
    MemRead = 0; MemWrite = 0; Funct3 = 0; Addr = 0; WrData = 0;
    mem_if.mem_ack = 0; mem_if.mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset RdData", RdData, 0);
    chk("reset stall", stall, 0);
    chk("reset req", mem_if.mem_req, 0);
    chk("reset addr", mem_if.mem_addr, 0);
    chk("reset timeout", timeout, 0);
    chk("reset misaligned", misaligned, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    access(1, 0, 3'd2, 32'h100, 0, 32'hDEAD_BEEF, 0, "lw 0x100");
    access(1, 0, 3'd0, 32'h103, 0, 32'h8011_2233, 0, "lb 0x103");
    access(1, 0, 3'd4, 32'h103, 0, 32'h8011_2233, 1, "lbu 0x103");
    access(1, 0, 3'd1, 32'h102, 0, 32'h8011_2233, 2, "lh 0x102");
    access(1, 0, 3'd5, 32'h102, 0, 32'h8011_2233, 0, "lhu 0x102");
    access(0, 1, 3'd1, 32'h206, 32'h0000_ABCD, 0, 0, "sh 0x206");
    access(0, 1, 3'd0, 32'h301, 32'h1234_56A5, 0, 3, "sb 0x301");
    access(1, 1, 3'd2, 32'h400, 32'hCAFE_F00D, 32'h1111_1111, 1, "rd+wr prio");
    access(1, 0, 3'd2, 32'h101, 0, 0, 0, "lw 0x101");
    access(1, 0, 3'd1, 32'h105, 0, 0, 0, "lh odd");
    access(1, 0, 3'd3, 32'h100, 0, 0, 0, "f3 011");
    access(1, 0, 3'd6, 32'h100, 0, 0, 0, "f3 110");
    access(0, 1, 3'd4, 32'h100, 32'h55, 0, 0, "sbu illegal");
    access(1, 0, 3'd2, 32'h104, 0, 32'h7777_7777, 0, "lw pre-timeout");
    access(1, 0, 3'd2, 32'h500, 0, 32'h9999_9999, TMO + 3, "lw timeout");

    access(1, 0, 3'd2, 32'h108, 0, 32'h0BAD_CAFE, 0, "lw pre-reset");
    MemRead = 1; MemWrite = 0; Funct3 = 3'd2; Addr = 32'h300; WrData = 0;
    @(negedge clk);
    #1 chk("rst-mid req1", mem_if.mem_req, 1);
    @(negedge clk);
    reset = 0; MemRead = 0;
    #1;
    chk("rst-mid req", mem_if.mem_req, 0);
    chk("rst-mid addr", mem_if.mem_addr, 0);
    chk("rst-mid we", mem_if.mem_we, 0);
    chk("rst-mid wmask", mem_if.mem_wmask, 0);
    chk("rst-mid wdata", mem_if.mem_wdata, 0);
    chk("rst-mid RdData", RdData, 0);
    chk("rst-mid stall", stall, 0);
    chk("rst-mid timeout", timeout, 0);
    chk("rst-mid misaligned", misaligned, 0);
    rd_model = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 chk("post-rst timeout", timeout, 0);
    access(1, 0, 3'd2, 32'h300, 0, 32'h1357_9BDF, 1, "lw post-reset");

    for (int i = 0; i < 150; i++) begin
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1;
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      access(rd, wr, f3, a, $urandom, $urandom, int'($urandom_range(0, TMO + 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
